// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared register map, status bits and TX state encoding
// Purpose: constants shared by the MMIO UART transmitter and its bench.
// Contents: register offsets (address[3:2]), STATUS bit indices, TX FSM state type.
package mmio_uart_tx_pkg;

    localparam logic [1:0] LEDS_OFF   = 2'd0;
    localparam logic [1:0] TXDATA_OFF = 2'd1;
    localparam logic [1:0] STATUS_OFF = 2'd2;
    localparam logic [1:0] BAUD_OFF   = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - processor data-bus interface for the MMIO UART block
// Purpose: groups the program-memory-style bus signals.
// Signals: address, read, writeData, writeMask (master -> slave), readData (slave -> master).
interface mmio_uart_tx_if;
    logic [31:0] address;
    logic        read;
    logic [31:0] writeData;
    logic [3:0]  writeMask;
    logic [31:0] readData;

    modport master (output address, read, writeData, writeMask, input readData);
    modport slave  (input address, read, writeData, writeMask, output readData);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - synchronous FIFO with combinational head output
// Purpose: TX byte buffer. Pushes to a full FIFO and pops from an empty one are ignored.
// Ports: CLK, RESET (async active-low), push, pop, din, dout (head), full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped LED register plus FIFO-buffered 8N1 UART transmitter
// Purpose: bus responder at BASE_ADDR with LEDS, TXDATA, STATUS and BAUD_DIV registers.
// Ports: CLK, RESET (async active-low), bus (slave modport), LEDS (LED register), TXD (serial out, idle high).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic               CLK,
    input  logic               RESET,
    mmio_uart_tx_if.slave      bus,
    output logic [31:0]        LEDS,
    output logic               TXD
);
    logic        sel, wr, push, pop, full, empty, busy;
    logic [1:0]  off;
    logic [7:0]  fifo_dout;
    logic [31:0] leds_q, rdata_q, rd_val;
    logic [15:0] baud_div_q;
    logic        ovf_q;

    tx_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] div_q, div_d;
    logic        bit_end;

    assign sel  = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign off  = bus.address[3:2];
    assign wr   = sel && (bus.writeMask != 4'b0000);
    assign push = wr && (off == TXDATA_OFF) && bus.writeMask[0];
    assign busy = (state_q != IDLE) || !empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .din   (bus.writeData[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        rd_val = 32'h0;
        case (off)
            LEDS_OFF:   rd_val = leds_q;
            STATUS_OFF: begin
                rd_val[ST_FULL]  = full;
                rd_val[ST_EMPTY] = empty;
                rd_val[ST_BUSY]  = busy;
                rd_val[ST_OVF]   = ovf_q;
            end
            BAUD_OFF:   rd_val = {16'h0, baud_div_q};
            default:    rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            leds_q     <= 32'h0;
            baud_div_q <= DEFAULT_DIV;
            ovf_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            // Unselected reads return 0 so several responders can be OR-ed.
            if (bus.read) rdata_q <= sel ? rd_val : 32'h0;
            if (wr && off == LEDS_OFF) begin
                for (int b = 0; b < 4; b++)
                    if (bus.writeMask[b]) leds_q[8*b +: 8] <= bus.writeData[8*b +: 8];
            end
            if (wr && off == BAUD_OFF) begin
                if (bus.writeMask[0]) baud_div_q[7:0]  <= bus.writeData[7:0];
                if (bus.writeMask[1]) baud_div_q[15:8] <= bus.writeData[15:8];
            end
            if (push && full)
                ovf_q <= 1'b1;
            else if (wr && off == STATUS_OFF && bus.writeMask[0] && bus.writeData[ST_OVF])
                ovf_q <= 1'b0;
        end
    end

    assign bit_end = (baud_cnt_q == div_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        pop        = 1'b0;
        // Frame load is shared by IDLE and the back-to-back path out of STOP.
        if ((state_q == IDLE || (state_q == STOP && bit_end)) && !empty) begin
            pop        = 1'b1;
            shift_d    = fifo_dout;
            div_d      = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
            bit_cnt_d  = 3'd0;
            baud_cnt_d = 16'd0;
            state_d    = START;
        end else if (state_q != IDLE) begin
            if (!bit_end) begin
                baud_cnt_d = baud_cnt_q + 16'd1;
            end else begin
                baud_cnt_d = 16'd0;
                case (state_q)
                    START: state_d = DATA;
                    DATA: begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = STOP;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            shift_q    <= 8'h0;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            div_q      <= 16'd1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
        end
    end

    always_comb begin
        case (state_q)
            START:   TXD = 1'b0;
            DATA:    TXD = shift_q[0];
            default: TXD = 1'b1;
        endcase
    end

    assign LEDS        = leds_q;
    assign bus.readData = rdata_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    logic        CLK;
    logic        RESET;
    logic [31:0] LEDS;
    logic        TXD;
    int          total;
    int          passed;

    mmio_uart_tx_if bus ();

    mmio_uart_tx dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave),
        .LEDS  (LEDS),
        .TXD   (TXD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge CLK);
        bus.address   = addr;
        bus.writeData = data;
        bus.writeMask = mask;
        @(negedge CLK);
        bus.writeMask = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge CLK);
        bus.address = addr;
        bus.read    = 1'b1;
        @(negedge CLK);
        bus.read    = 1'b0;
        data        = bus.readData;
    endtask

    // 10-bit frame, index 0 = start bit, 9 = stop bit
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[idx];
    endfunction

    initial begin
        logic [31:0] rd;
        logic [63:0] got, exp;
        logic [7:0]  bytes_q [6];
        int          budget;

        total = 0;
        passed = 0;
        RESET = 1'b0;
        bus.address = 32'h0;
        bus.read = 1'b0;
        bus.writeData = 32'h0;
        bus.writeMask = 4'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        check("reset_txd", 64'(TXD), 64'd1);
        check("reset_leds", 64'(LEDS), 64'h0);
        check("reset_rdata", 64'(bus.readData), 64'h0);
        bus_read(32'h1008, rd);
        check("reset_status", 64'(rd), 64'h2);
        bus_read(32'h100C, rd);
        check("reset_baud", 64'(rd), 64'd868);

        // LED byte masking
        bus_write(32'h1000, 32'hAABBCCDD, 4'b0011);
        check("leds_mask_lo", 64'(LEDS), 64'h0000CCDD);
        bus_read(32'h1000, rd);
        check("leds_readback", 64'(rd), 64'h0000CCDD);
        bus_write(32'h1000, 32'h11223344, 4'b1100);
        check("leds_mask_hi", 64'(LEDS), 64'h1122CCDD);
        bus_read(32'h1004, rd);
        check("txdata_read_zero", 64'(rd), 64'h0);

        // Single frame, DIV=4, byte 0x55
        bus_write(32'h100C, 32'h0000_0004, 4'b0011);
        bus_read(32'h100C, rd);
        check("baud_readback", 64'(rd), 64'h4);
        bus_write(32'h1004, 32'h0000_0055, 4'b0001);
        check("txd_idle_before_pop", 64'(TXD), 64'd1);
        got = '0;
        exp = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            got[i] = TXD;
            exp[i] = frame_bit(8'h55, i / 4);
        end
        check("frame_55_div4", got, exp);
        // Last sample was the final STOP cycle; busy must fall on the next edge
        bus.address = 32'h1008;
        bus.read = 1'b1;
        @(negedge CLK);
        check("busy_last_stop_cycle", 64'(bus.readData), 64'h6);
        @(negedge CLK);
        bus.read = 1'b0;
        check("busy_dropped", 64'(bus.readData), 64'h2);

        // Overflow: DIV=100, six pushes on consecutive cycles
        bus_write(32'h100C, 32'd100, 4'b0011);
        @(negedge CLK);
        bus.address = 32'h1004;
        bus.writeMask = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            bus.writeData = 32'(8'h10 + k);
            @(negedge CLK);
        end
        bus.writeMask = 4'b0000;
        bus_read(32'h1008, rd);
        check("status_overflow", 64'(rd), 64'hD);
        bus_write(32'h1008, 32'h0000_0008, 4'b0001);
        bus_read(32'h1008, rd);
        check("overflow_cleared", 64'(rd), 64'h5);
        budget = 0;
        rd = 32'h4;
        while (rd[2] && budget < 4000) begin
            bus_read(32'h1008, rd);
            budget++;
        end
        check("drain_idle", 64'(rd), 64'h2);

        // Back-to-back frames, DIV=2
        bus_write(32'h100C, 32'd2, 4'b0011);
        bytes_q[0] = 8'hA5;
        bytes_q[1] = 8'h3C;
        @(negedge CLK);
        bus.address = 32'h1004;
        bus.writeMask = 4'b0001;
        bus.writeData = 32'h0000_00A5;
        @(negedge CLK);
        bus.writeData = 32'h0000_003C;
        @(negedge CLK);
        bus.writeMask = 4'b0000;
        got = '0;
        exp = '0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge CLK);
            got[i] = TXD;
            exp[i] = frame_bit(bytes_q[i / 20], (i % 20) / 2);
        end
        check("b2b_frames", got, exp);
        bus_read(32'h1008, rd);
        check("b2b_idle_after", 64'(rd), 64'h2);

        // Reset mid-frame during DATA (byte 0x00 keeps TXD low in DATA)
        bus_write(32'h100C, 32'd4, 4'b0011);
        bus_write(32'h1004, 32'h0000_0000, 4'b0001);
        bus_write(32'h1004, 32'h0000_0077, 4'b0001);
        bus_read(32'h1008, rd);
        check("status_before_reset", 64'(rd), 64'h4);
        repeat (4) @(negedge CLK);
        check("txd_data_low", 64'(TXD), 64'd0);
        #2;
        RESET = 1'b0;
        #1;
        check("async_reset_txd", 64'(TXD), 64'd1);
        check("async_reset_leds", 64'(LEDS), 64'h0);
        check("async_reset_rdata", 64'(bus.readData), 64'h0);
        @(negedge CLK);
        RESET = 1'b1;
        bus_read(32'h1008, rd);
        check("fifo_empty_after_reset", 64'(rd), 64'h2);
        got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            got[i] = ~TXD;
        end
        check("no_frame_resumes", got, 64'h0);

        // Address decode and readData hold
        bus_write(32'h1000, 32'h12345678, 4'b1111);
        bus_write(32'h2000, 32'hFFFFFFFF, 4'b1111);
        check("unselected_write_ignored", 64'(LEDS), 64'h12345678);
        bus_read(32'h1000, rd);
        check("leds_full_read", 64'(rd), 64'h12345678);
        bus_read(32'h2000, rd);
        check("unselected_read_zero", 64'(rd), 64'h0);
        bus_read(32'h1000, rd);
        bus.address = 32'h100C;
        repeat (3) @(negedge CLK);
        check("rdata_holds", 64'(bus.readData), 64'h12345678);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the processor data bus: address, read, writeData, writeMask and readData, with the same timing as program memory.
- Provides an LED output register, a programmable baud divisor, a status register, and a FIFO-buffered 8N1 UART transmitter.
- Sits beside program memory in SOC and drives the LEDS output and a serial TXD pin.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte base address. Block is selected when address[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of two, ≥2.
- DEFAULT_DIV, 16'd868: reset value of BAUD_DIV, in clock cycles per bit.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- address  in  32  byte address from the processor.
- read  in  1  read strobe.
- writeData  in  32  write data, already lane-aligned by the processor.
- writeMask  in  4  byte-lane write enables. Nonzero means a write.
- readData  out  32  registered read data.
- LEDS  out  32  LED register contents.
- TXD  out  1  UART serial output, idle high.

Behaviour:
- Register map (offset = address[3:2]):
  - 0x0 LEDS: read/write, honours writeMask per byte.
  - 0x4 TXDATA: a write with writeMask[0]=1 pushes writeData[7:0] into the FIFO. Reads return 0.
  - 0x8 STATUS: read-only bits. bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky). Writing 1 to bit3 (writeMask[0]=1) clears it. Other bits read 0.
  - 0xC BAUD_DIV: bits[15:0] read/write, honours writeMask[1:0]. Upper bits read 0.
- Read timing:
  - read=1 and selected → readData <= register value at the next rising edge (1-cycle latency).
  - read=1 and not selected → readData <= 0, so the bus can be OR-combined.
  - read=0 → readData holds.
- Writes: take effect on the rising edge where writeMask≠0 and the block is selected. read and writeMask are never both active in the same cycle.
- FIFO:
  - Push to a full FIFO drops the byte and sets overflow.
  - A simultaneous push and pop both happen; count is unchanged.
  - A push to an empty FIFO while the transmitter is IDLE is popped on the following edge.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty → at that edge: pop the head into an 8-bit shift register, latch the active divisor, clear the bit counter and baud counter, go to START.
  - Active divisor = BAUD_DIV, except 0 is treated as 1.
  - Each state bit lasts exactly DIV cycles, counted by the baud counter from 0 to DIV-1.
  - START: TXD=0.
  - DATA: TXD=shift[0], LSB first. Shift right at each bit end. After 8 bits go to STOP.
  - STOP: TXD=1. At its end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - A BAUD_DIV write mid-frame affects only the next frame.
- busy = (state≠IDLE) or FIFO non-empty.
- Reset (asynchronous, any time, including mid-frame):
  - TXD=1, LEDS=0, readData=0.
  - FIFO empty, overflow=0, BAUD_DIV=DEFAULT_DIV, state=IDLE, all counters 0.
  - No partial frame resumes after release.
- Width rules: baud counter is 16 bits. Bit counter is 3 bits. FIFO pointers are log2(FIFO_DEPTH) bits, wrapping, with a count of log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package holds:
  - Register offsets: LEDS_OFF, TXDATA_OFF, STATUS_OFF, BAUD_OFF.
  - STATUS bit indices.
  - TX state encoding localparams: IDLE=0, START=1, DATA=2, STOP=3.
- Sub-module sync_fifo: parameterised width/depth. Ports: push, pop, din, dout (head, combinational), full, empty. Same CLK and active-low asynchronous RESET.

Test Plan:
- Reset: release RESET, read STATUS → readData=32'h0000_0002 one cycle after read. TXD=1, LEDS=0.
- LED masking: write 32'hAABBCCDD to 0x1000 with writeMask=4'b0011 → LEDS=32'h0000CCDD. Read-back matches.
- Frame timing: BAUD_DIV=4, write 8'h55 to TXDATA.
  - TXD=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - busy drops 40 cycles after the pop.
- Overflow: BAUD_DIV=100, push 6 bytes on consecutive cycles.
  - Byte 1 is popped, bytes 2–5 fill the FIFO, byte 6 is dropped.
  - STATUS=32'hD (full, busy, overflow).
  - Write 8'h08 to STATUS → overflow clears.
- Back-to-back: BAUD_DIV=2, push 8'hA5 and 8'h3C → STOP of frame 1 is followed immediately by START of frame 2. Total 40 cycles of activity.
- Reset mid-frame and decode: assert RESET during DATA → TXD=1 asynchronously, FIFO empty. Read at 0x2000 → readData=0. With read=0, readData holds its previous value.
